// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch unit's control inputs, memory request/response channel,
// decoder handoff channel and status outputs. master = fetch unit, slave = environment.
interface instruction_fetch_unit_if;
  logic        i_enable;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_busy;
  logic        o_fault;
  logic [1:0]  o_fault_cause;

  modport master (
    input  i_enable, i_pc, i_flush, i_mem_req_ready, i_mem_rsp_valid,
           i_mem_rsp_data, i_instr_ready,
    output o_mem_req_valid, o_mem_addr, o_instr_valid, o_instr, o_instr_pc,
           o_busy, o_fault, o_fault_cause
  );

  modport slave (
    output i_enable, i_pc, i_flush, i_mem_req_ready, i_mem_rsp_valid,
           i_mem_rsp_data, i_instr_ready,
    input  o_mem_req_valid, o_mem_addr, o_instr_valid, o_instr, o_instr_pc,
           o_busy, o_fault, o_fault_cause
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: samples the PC, issues one word read, holds the
// returned instruction (tagged with its PC) for the decoder. Redirects abort
// or drain stale fetches; misalignment and memory timeouts latch a sticky fault.
module instruction_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          ipc_q, ipc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]           cause_q, cause_d;
  logic                 req_vld_q, ivld_q, busy_q, fault_q;
  logic                 timeout;

  // Saturating increment; timeout fires on the cycle the count would reach the limit.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    timeout = (cnt_inc >= TO_LIMIT);
  end

  // Next-state, counter and datapath capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else if (bus.i_enable) begin
          if (bus.i_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            cause_d = CAUSE_MISALGN;
          end else begin
            addr_d  = bus.i_pc;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An accepted request is outstanding even if flushed: its response must be drained.
        if (bus.i_mem_req_ready) begin
          cnt_d   = '0;
          state_d = bus.i_flush ? S_DRAIN : S_WAIT;
        end else if (bus.i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.i_mem_rsp_valid) begin
          if (bus.i_flush) begin
            state_d = S_IDLE;
          end else begin
            instr_d = bus.i_mem_rsp_data;
            ipc_d   = addr_q;
            state_d = S_HOLD;
          end
        end else if (bus.i_flush) begin
          state_d = S_DRAIN;
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_HOLD: begin
        if (bus.i_flush || bus.i_instr_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Counter keeps running from WAIT so the bound covers the whole outstanding window.
        cnt_d = cnt_inc;
        if (bus.i_mem_rsp_valid) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      instr_q   <= '0;
      ipc_q     <= '0;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      req_vld_q <= 1'b0;
      ivld_q    <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      req_vld_q <= (state_d == S_REQ);
      ivld_q    <= (state_d == S_HOLD);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign bus.o_mem_req_valid = req_vld_q;
  assign bus.o_mem_addr      = addr_q;
  assign bus.o_instr_valid   = ivld_q;
  assign bus.o_instr         = instr_q;
  assign bus.o_instr_pc      = ipc_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_fault         = fault_q;
  assign bus.o_fault_cause   = cause_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected
// request addresses and instruction handoffs; a negedge monitor pops and compares.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] exp_req[$];
  exp_t        exp_instr[$];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_instr.push_back(e);
  endtask

  // Monitor: every accepted request and every decoder handoff must match the scoreboard.
  initial begin
    logic [31:0] a;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
          if (exp_req.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: addr %h with none expected", bus.o_mem_addr);
          end else begin
            a = exp_req.pop_front();
            chk("req_addr", bus.o_mem_addr, a);
          end
        end
        if (bus.o_instr_valid && bus.i_instr_ready && !bus.i_flush) begin
          if (exp_instr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_instr: %h @ %h with none expected", bus.o_instr, bus.o_instr_pc);
          end else begin
            e = exp_instr.pop_front();
            chk("instr", bus.o_instr, e.instr);
            chk("instr_pc", bus.o_instr_pc, e.pc);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] b2b_data[3];
    b2b_data[0] = 32'h0000_0093;
    b2b_data[1] = 32'h0010_8093;
    b2b_data[2] = 32'h0020_8113;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_enable        = 1'b0;
    bus.i_pc            = '0;
    bus.i_flush         = 1'b0;
    bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_data  = '0;
    bus.i_instr_ready   = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_req_valid", 32'(bus.o_mem_req_valid), 0);
    chk("rst_instr_valid", 32'(bus.o_instr_valid), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_fault", 32'(bus.o_fault), 0);
    chk("rst_cause", 32'(bus.o_fault_cause), 0);
    chk("rst_addr", bus.o_mem_addr, 0);

    // Single fetch: valid 3 cycles after enable, held until decoder ready
    bus.i_pc = 32'h0; bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b1;
    exp_req.push_back(32'h0);
    push_instr(32'h0000_0013, 32'h0);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    chk("t1_req_valid", 32'(bus.o_mem_req_valid), 1);
    chk("t1_busy", 32'(bus.o_busy), 1);
    tick();                                   // WAIT
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = 32'h0000_0013;
    chk("t1_ivalid_early", 32'(bus.o_instr_valid), 0);
    tick();                                   // HOLD
    bus.i_mem_rsp_valid = 1'b0;
    chk("t1_ivalid", 32'(bus.o_instr_valid), 1);
    tick(); tick();
    chk("t1_hold_valid", 32'(bus.o_instr_valid), 1);
    chk("t1_hold_instr", bus.o_instr, 32'h0000_0013);
    bus.i_instr_ready = 1'b1;
    tick();                                   // IDLE
    bus.i_instr_ready = 1'b0;
    chk("t1_idle_valid", 32'(bus.o_instr_valid), 0);
    chk("t1_idle_busy", 32'(bus.o_busy), 0);

    // Back-to-back fetches 0,4,8: one request every 4 cycles
    bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b1; bus.i_instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_pc = 32'(4 * k);
      exp_req.push_back(32'(4 * k));
      push_instr(b2b_data[k], 32'(4 * k));
      tick();                                 // REQ
      chk("b2b_req_valid", 32'(bus.o_mem_req_valid), 1);
      tick();                                 // WAIT
      bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = b2b_data[k];
      chk("b2b_wait_novalid", 32'(bus.o_mem_req_valid), 0);
      tick();                                 // HOLD
      bus.i_mem_rsp_valid = 1'b0;
      if (k == 2) bus.i_enable = 1'b0;
      chk("b2b_ivalid", 32'(bus.o_instr_valid), 1);
      tick();                                 // IDLE
      chk("b2b_idle_req", 32'(bus.o_mem_req_valid), 0);
    end
    bus.i_instr_ready = 1'b0;
    tick();

    // Flush in WAIT, stale response two cycles later, then refetch at 0x100
    bus.i_pc = 32'h20; bus.i_enable = 1'b1;
    exp_req.push_back(32'h20);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    tick();                                   // WAIT
    bus.i_flush = 1'b1;
    tick();                                   // DRAIN
    bus.i_flush = 1'b0;
    chk("t3_drain_busy", 32'(bus.o_busy), 1);
    tick();
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = 32'hDEAD_BEEF;
    tick();                                   // IDLE
    bus.i_mem_rsp_valid = 1'b0;
    chk("t3_stale_valid", 32'(bus.o_instr_valid), 0);
    bus.i_pc = 32'h100; bus.i_enable = 1'b1;
    exp_req.push_back(32'h100);
    push_instr(32'h1234_5678, 32'h100);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    chk("t3_req_addr", bus.o_mem_addr, 32'h100);
    chk("t3_novalid", 32'(bus.o_instr_valid), 0);
    tick();                                   // WAIT
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = 32'h1234_5678;
    tick();                                   // HOLD
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_instr_ready = 1'b1;
    chk("t3_new_instr", bus.o_instr, 32'h1234_5678);
    tick();
    bus.i_instr_ready = 1'b0;

    // Request stalled 5 cycles then flushed: address stable, valid drops next cycle
    bus.i_pc = 32'h40; bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b0;
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 32'(bus.o_mem_req_valid), 1);
      chk("t4_stall_addr", bus.o_mem_addr, 32'h40);
      tick();
    end
    bus.i_flush = 1'b1;
    tick();                                   // IDLE
    bus.i_flush = 1'b0;
    chk("t4_abort_valid", 32'(bus.o_mem_req_valid), 0);
    chk("t4_abort_busy", 32'(bus.o_busy), 0);

    // Flush in HOLD beats a simultaneous decoder ready
    bus.i_pc = 32'h200; bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b1;
    exp_req.push_back(32'h200);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    tick();                                   // WAIT
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = 32'h55;
    tick();                                   // HOLD
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_flush = 1'b1; bus.i_instr_ready = 1'b1;
    tick();                                   // IDLE
    bus.i_flush = 1'b0; bus.i_instr_ready = 1'b0;
    chk("t5_hold_flush", 32'(bus.o_instr_valid), 0);

    // Reset mid-WAIT, late response ignored
    bus.i_pc = 32'h80; bus.i_enable = 1'b1;
    exp_req.push_back(32'h80);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    tick();                                   // WAIT
    bus.i_mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_mem_rsp_valid = 1'b1; bus.i_mem_rsp_data = 32'hCAFE_F00D;
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    chk("t6_late_valid", 32'(bus.o_instr_valid), 0);
    chk("t6_late_busy", 32'(bus.o_busy), 0);
    tick();
    chk("t6_late_instr", bus.o_instr, 32'h0);

    // Timeout: no response for 8 WAIT cycles -> fault cause 2
    bus.i_pc = 32'hC0; bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b1;
    exp_req.push_back(32'hC0);
    tick();                                   // REQ
    bus.i_enable = 1'b0;
    tick();                                   // WAIT
    bus.i_mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t7_wait_nofault", 32'(bus.o_fault), 0);
      tick();
    end
    chk("t7_fault", 32'(bus.o_fault), 1);
    chk("t7_cause", 32'(bus.o_fault_cause), 2);
    chk("t7_busy", 32'(bus.o_busy), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_fault", 32'(bus.o_fault), 0);

    // Misaligned PC -> fault cause 1 next cycle, sticky until reset
    bus.i_pc = 32'h6; bus.i_enable = 1'b1; bus.i_mem_req_ready = 1'b1;
    tick();
    chk("t8_fault", 32'(bus.o_fault), 1);
    chk("t8_cause", 32'(bus.o_fault_cause), 1);
    chk("t8_noreq", 32'(bus.o_mem_req_valid), 0);
    bus.i_pc = 32'h0;
    tick(); tick(); tick();
    chk("t8_sticky", 32'(bus.o_fault), 1);
    chk("t8_sticky_noreq", 32'(bus.o_mem_req_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.i_enable = 1'b0;
    chk("t8_rst_fault", 32'(bus.o_fault), 0);
    chk("t8_rst_cause", 32'(bus.o_fault_cause), 0);
    chk("t8_rst_instr", bus.o_instr, 0);
    chk("t8_rst_ipc", bus.o_instr_pc, 0);
    chk("t8_rst_addr", bus.o_mem_addr, 0);
    tick(); tick();

    // Everything scheduled must have been observed
    chk("req_queue_left", 32'(exp_req.size()), 0);
    chk("instr_queue_left", 32'(exp_instr.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
